// File: rtl/tt_cc_pkg.sv
// tt_cc_pkg: shared types, frame constants and checksum helper for the token UART framer.
package tt_cc_pkg;
  typedef enum logic [1:0] {IDLE, START_BIT, DATA_BITS, STOP_BIT} framer_state_t;
  localparam int FRAME_BYTES = 11;
  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;
  function automatic logic [7:0] frame_chk(input logic [7:0] st, input logic [63:0] tok);
    logic [7:0] c;
    c = st;
    for (int i = 0; i < 8; i++) c ^= tok[8*i +: 8];
    return c;
  endfunction
endpackage

// File: rtl/uart_tx_byte.sv
// uart_tx_byte: 8N1 byte serialiser with registered tx; done marks the last stop-bit cycle.
module uart_tx_byte
  import tt_cc_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       abort,
  input  logic       load,
  input  logic [7:0] data,
  output logic       tx,
  output logic       done,
  output logic       busy
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  framer_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic          tx_q, tx_d;
  logic          tick;
  assign tick = cnt_q == CW'(CLKS_PER_BIT - 1);
  assign tx   = tx_q;
  assign busy = state_q != IDLE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      tx_q    <= tx_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = (state_q == IDLE || tick) ? '0 : cnt_q + 1'b1;
    bit_d   = bit_q;
    sh_d    = sh_q;
    tx_d    = tx_q;
    done    = 1'b0;
    case (state_q)
      IDLE: if (load) begin
        state_d = START_BIT;
        sh_d    = data;
        tx_d    = 1'b0;
      end
      START_BIT: if (tick) begin
        state_d = DATA_BITS;
        bit_d   = '0;
        tx_d    = sh_q[0];
      end
      DATA_BITS: if (tick) begin
        state_d = (bit_q == 3'd7) ? STOP_BIT : DATA_BITS;
        bit_d   = (bit_q == 3'd7) ? 3'd0 : bit_q + 3'd1;
        sh_d    = sh_q >> 1;
        tx_d    = (bit_q == 3'd7) ? 1'b1 : sh_q[1];
      end
      STOP_BIT: if (tick) begin
        // a load on the final stop cycle chains the next start bit with no idle gap
        done    = 1'b1;
        state_d = load ? START_BIT : IDLE;
        sh_d    = load ? data : sh_q;
        tx_d    = !load;
      end
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d = IDLE;
      cnt_d   = '0;
      bit_d   = '0;
      tx_d    = 1'b1;
    end
  end
endmodule

// File: rtl/token_uart_framer.sv
// token_uart_framer: sends SYNC, status, 8 token bytes and an XOR checksum as one 8N1 UART frame.
module token_uart_framer
  import tt_cc_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 16,
  parameter logic [7:0] SYNC_BYTE    = SYNC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        token_valid,
  input  logic [63:0] token64,
  input  logic [7:0]  status_in,
  output logic        tx,
  output logic        busy,
  output logic        frame_done,
  output logic        overrun
);
  logic [63:0] tok_q, tok_d;
  logic [7:0]  stat_q, stat_d, chk_q, chk_d;
  logic [3:0]  idx_q, idx_d, nxt;
  logic        ovr_q, ovr_d, fd_q, fd_d;
  logic        accept, last, done, load;
  logic [2:0]  tb_sel;
  logic [7:0]  load_data;
  uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
    .clk   (clk),
    .rst_n (rst_n),
    .abort (start),
    .load  (load),
    .data  (load_data),
    .tx    (tx),
    .done  (done),
    .busy  (busy)
  );
  assign frame_done = fd_q;
  assign overrun    = ovr_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tok_q  <= '0;
      stat_q <= '0;
      chk_q  <= '0;
      idx_q  <= '0;
      ovr_q  <= 1'b0;
      fd_q   <= 1'b0;
    end else begin
      tok_q  <= tok_d;
      stat_q <= stat_d;
      chk_q  <= chk_d;
      idx_q  <= idx_d;
      ovr_q  <= ovr_d;
      fd_q   <= fd_d;
    end
  end
  always_comb begin
    accept    = token_valid && !start && !busy;
    last      = idx_q == 4'(FRAME_BYTES - 1);
    nxt       = idx_q + 4'd1;
    tb_sel    = 3'(nxt - 4'd2);
    load      = accept || (done && !last);
    // the first byte is a constant, so accept can load before the latches update
    load_data = accept ? SYNC_BYTE :
                nxt == 4'd1 ? stat_q :
                nxt == 4'(FRAME_BYTES - 1) ? chk_q : tok_q[{tb_sel, 3'b000} +: 8];
    tok_d     = accept ? token64 : tok_q;
    stat_d    = accept ? status_in : stat_q;
    chk_d     = accept ? frame_chk(status_in, token64) : chk_q;
    idx_d     = (start || accept) ? 4'd0 : (done && !last) ? nxt : idx_q;
    ovr_d     = start ? 1'b0 : (token_valid && busy) ? 1'b1 : ovr_q;
    fd_d      = done && last && !start;
  end
endmodule
